pingpong_frame_buffer: RTL and testbench

Double-buffered (ping-pong) single-clock frame store between the pixel producer (camera or convolution output) and `vga_driver`. The producer writes a complete source frame into one bank by address. The other bank streams out in raster order at the output resolution, optionally upscaled 2x by pixel/line replication, paced by the driver's `ready`. Banks swap only at output frame boundaries, so the display never tears.

---
 rtl/pingpong_frame_buffer.sv | 142 ++++++++++++++
 tb/tb_pingpong_frame_buffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_frame_buffer.sv
// Ping-pong frame store: the producer fills one bank by address while the other
// streams out in raster order, optionally 2x upscaled, paced by the consumer's ready.
module pingpong_frame_buffer #(
    parameter int PIX_W    = 12,
    parameter int SRC_COLS = 320,
    parameter int SRC_ROWS = 240,
    parameter int ADDR_W   = 17,
    parameter int UPSCALE  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wren,
    input  logic [ADDR_W-1:0] wraddress,
    input  logic [PIX_W-1:0]  data_in,
    input  logic              wr_frame_done,
    input  logic              ready,
    output logic [PIX_W-1:0]  data_out,
    output logic              valid,
    output logic              image_start,
    output logic              image_end,
    output logic              frame_dropped,
    output logic              addr_err
);

    localparam int DEPTH    = SRC_COLS * SRC_ROWS;
    localparam int MW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OUT_COLS = SRC_COLS * UPSCALE;
    localparam int OUT_ROWS = SRC_ROWS * UPSCALE;
    localparam int XW       = $clog2(OUT_COLS + 1);
    localparam int YW       = $clog2(OUT_ROWS + 1);
    localparam int S        = (UPSCALE == 2) ? 1 : 0;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

    state_t            state, state_n;
    logic [PIX_W-1:0]  mem0 [DEPTH];
    logic [PIX_W-1:0]  mem1 [DEPTH];
    logic              wr_bank, rd_bank, pending;
    logic              wr_bank_n, rd_bank_n, pending_n;
    logic [XW-1:0]     ox, ox_n;
    logic [YW-1:0]     oy, oy_n;
    logic [MW-1:0]     row_base, row_base_n;
    logic [MW-1:0]     rd_addr;
    logic              rd_en, swap, in_range;
    logic              start_n, end_n;

    assign in_range = ({1'b0, wraddress} < DEPTH_L);
    assign valid    = (state == STREAM);

    // Writes target the pre-swap bank; the read side never touches that bank.
    always_ff @(posedge clk) begin
        if (wren && in_range) begin
            if (wr_bank) mem1[wraddress[MW-1:0]] <= data_in;
            else         mem0[wraddress[MW-1:0]] <= data_in;
        end
    end

    always_comb begin
        state_n    = state;
        ox_n       = ox;
        oy_n       = oy;
        row_base_n = row_base;
        swap       = 1'b0;
        rd_en      = 1'b0;
        case (state)
            IDLE: begin
                if (wr_frame_done || pending) begin
                    swap    = 1'b1;
                    state_n = PRIME;
                end
            end
            PRIME: begin
                rd_en      = 1'b1;
                state_n    = STREAM;
                ox_n       = '0;
                oy_n       = '0;
                row_base_n = '0;
            end
            STREAM: begin
                if (ready) begin
                    rd_en = 1'b1;
                    if (ox == XW'(OUT_COLS - 1)) begin
                        ox_n = '0;
                        if (oy == YW'(OUT_ROWS - 1)) begin
                            oy_n       = '0;
                            row_base_n = '0;
                            swap       = pending || wr_frame_done;
                        end else begin
                            oy_n = oy + YW'(1);
                            // Source row advances after every replicated line pair.
                            if (S == 0 || oy[0]) row_base_n = row_base + MW'(SRC_COLS);
                        end
                    end else begin
                        ox_n = ox + XW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        wr_bank_n = swap ? ~wr_bank : wr_bank;
        rd_bank_n = swap ? wr_bank : rd_bank;
        pending_n = swap ? 1'b0 : (wr_frame_done ? 1'b1 : pending);
        // Address of the position presented next, so the read lands without a bubble.
        rd_addr   = row_base_n + MW'(ox_n >> S);
        start_n   = (ox_n == '0) && (oy_n == '0);
        end_n     = (ox_n == XW'(OUT_COLS - 1)) && (oy_n == YW'(OUT_ROWS - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ox            <= '0;
            oy            <= '0;
            row_base      <= '0;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b1;
            pending       <= 1'b0;
            data_out      <= '0;
            image_start   <= 1'b0;
            image_end     <= 1'b0;
            frame_dropped <= 1'b0;
            addr_err      <= 1'b0;
        end else begin
            state         <= state_n;
            ox            <= ox_n;
            oy            <= oy_n;
            row_base      <= row_base_n;
            wr_bank       <= wr_bank_n;
            rd_bank       <= rd_bank_n;
            pending       <= pending_n;
            frame_dropped <= wr_frame_done && pending;
            if (wren && !in_range) addr_err <= 1'b1;
            if (rd_en) begin
                data_out    <= rd_bank_n ? mem1[rd_addr] : mem0[rd_addr];
                image_start <= start_n;
                image_end   <= end_n;
            end
        end
    end

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Directed bench for pingpong_frame_buffer on a 4x2 source with 2x upscale,
// checked every cycle against a frame-index model plus literal expectations.
module tb_pingpong_frame_buffer;

    localparam int C    = 4;
    localparam int R    = 2;
    localparam int U    = 2;
    localparam int OC   = C * U;
    localparam int NPIX = C * R * U * U;

    logic        clk = 1'b0;
    logic        rst;
    logic        wren;
    logic [3:0]  wraddress;
    logic [11:0] data_in;
    logic        wr_frame_done;
    logic        ready;
    logic [11:0] data_out;
    logic        valid, image_start, image_end, frame_dropped, addr_err;

    pingpong_frame_buffer #(
        .PIX_W(12), .SRC_COLS(C), .SRC_ROWS(R), .ADDR_W(4), .UPSCALE(U)
    ) dut (
        .clk(clk), .rst(rst), .wren(wren), .wraddress(wraddress), .data_in(data_in),
        .wr_frame_done(wr_frame_done), .ready(ready), .data_out(data_out),
        .valid(valid), .image_start(image_start), .image_end(image_end),
        .frame_dropped(frame_dropped), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: output stream as a linear pixel index into the displayed bank.
    logic [11:0] mbank [2][8];
    int          m_phase, m_k;
    bit          m_wrb, m_rdb, m_pend, m_drop, m_err, m_sw, m_newr;
    logic [11:0] m_data;

    function automatic int src_of(input int k);
        return ((k / OC) / U) * C + (k % OC) / U;
    endfunction

    initial foreach (mbank[b, a]) mbank[b][a] = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_k = 0; m_wrb = 0; m_rdb = 1; m_pend = 0;
            m_drop = 0; m_err = 0; m_data = '0;
        end else begin
            m_sw   = 0;
            m_drop = wr_frame_done && m_pend;
            case (m_phase)
                0: if (wr_frame_done || m_pend) begin m_sw = 1; m_phase = 1; end
                1: begin m_phase = 2; m_k = 0; m_data = mbank[m_rdb][src_of(0)]; end
                default: if (ready) begin
                    if (m_k == NPIX - 1) begin
                        m_k  = 0;
                        m_sw = m_pend || wr_frame_done;
                    end else m_k++;
                    m_newr = m_sw ? m_wrb : m_rdb;
                    m_data = mbank[m_newr][src_of(m_k)];
                end
            endcase
            if (wren) begin
                if (wraddress < 4'd8) mbank[m_wrb][wraddress[2:0]] = data_in;
                else m_err = 1;
            end
            if (m_sw) begin m_rdb = m_wrb; m_wrb = !m_wrb; m_pend = 0; end
            else if (wr_frame_done) m_pend = 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_valid", valid, m_phase == 2);
            chk("m_start", image_start, m_phase == 2 && m_k == 0);
            chk("m_end", image_end, m_phase == 2 && m_k == NPIX - 1);
            chk("m_data", data_out, m_data);
            chk("m_dropped", frame_dropped, m_drop);
            chk("m_addr_err", addr_err, m_err);
        end
    end

    // Handshake monitor.
    logic [11:0] q_data[$];
    bit          q_end[$];
    int          drop_cnt = 0;
    always @(negedge clk) begin
        if (valid && ready) begin
            q_data.push_back(data_out);
            q_end.push_back(image_end);
        end
        if (frame_dropped) drop_cnt++;
    end

    int exp_frame [32] = '{0,0,1,1,2,2,3,3, 0,0,1,1,2,2,3,3,
                           4,4,5,5,6,6,7,7, 4,4,5,5,6,6,7,7};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        wren = 1'b1; wraddress = 4'(a); data_in = 12'(d);
        tick;
        wren = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, j_end;
        rst = 1'b1; wren = 1'b0; wraddress = '0; data_in = '0;
        wr_frame_done = 1'b0; ready = 1'b1;
        tick; tick;
        cmp_en = 1'b1;
        chk("reset_valid", valid, 0);
        chk("reset_data", data_out, 0);
        chk("reset_err", addr_err, 0);
        rst = 1'b0;
        tick;

        // Startup
        for (int i = 0; i < 8; i++) wr(i, i);
        wr_frame_done = 1'b1; tick; wr_frame_done = 1'b0;
        chk("prime_valid", valid, 0);
        q_data.delete(); q_end.delete();
        tick;
        chk("first_valid", valid, 1);
        chk("first_data", data_out, 0);
        chk("first_start", image_start, 1);
        n = 0;
        while (q_data.size() < 2 * NPIX && n < 200) begin tick; n++; end
        chk("stream_budget", q_data.size() >= 2 * NPIX, 1);
        if (q_data.size() >= 2 * NPIX) begin
            for (int i = 0; i < 2 * NPIX; i++) begin
                chk("startup_seq", q_data[i], exp_frame[i % NPIX]);
                chk("startup_end", q_end[i], (i % NPIX) == NPIX - 1);
            end
        end

        // Swap mid-frame
        for (int i = 0; i < 8; i++) wr(i, 100 + i);
        wr_frame_done = 1'b1;
        q_data.delete(); q_end.delete();
        tick; wr_frame_done = 1'b0;
        j_end = -1; n = 0;
        while ((j_end < 0 || q_data.size() <= j_end + 1) && n < 100) begin
            tick; n++;
            if (j_end < 0) foreach (q_end[j]) if (q_end[j] && j_end < 0) j_end = j;
        end
        chk("swap_budget", j_end >= 0 && q_data.size() > j_end + 1, 1);
        if (j_end >= 0 && q_data.size() > j_end + 1) begin
            chk("swap_last_old", q_data[j_end], 7);
            chk("swap_first_new", q_data[j_end + 1], 100);
        end

        // Simultaneous swap at last-pixel handshake, then a dropped frame
        for (int i = 0; i < 8; i++) wr(i, 200 + i);
        n = 0;
        while (!image_end && n < 100) begin tick; n++; end
        chk("sim_budget", image_end, 1);
        wr_frame_done = 1'b1; tick; wr_frame_done = 1'b0;
        chk("sim_first_new", data_out, 200);
        chk("sim_start", image_start, 1);
        drop_cnt = 0;
        repeat (3) tick;
        wr_frame_done = 1'b1; tick; wr_frame_done = 1'b0;
        repeat (3) tick;
        wr_frame_done = 1'b1; tick; wr_frame_done = 1'b0;
        repeat (3) tick;
        chk("drop_once", drop_cnt, 1);

        // Backpressure
        repeat (200) begin
            ready = 1'($urandom_range(0, 1));
            tick;
        end
        ready = 1'b1;

        // Out-of-range write: must not alias into bank 0 address 0
        wr(8, 12'hABC);
        chk("addr_err_set", addr_err, 1);
        repeat (5) tick;

        // Reset mid-frame and restart from bank 0
        rst = 1'b1; #1;
        chk("rst_valid", valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_start", image_start, 0);
        chk("rst_end", image_end, 0);
        chk("rst_err", addr_err, 0);
        tick; tick;
        rst = 1'b0;
        tick;
        wr_frame_done = 1'b1; tick; wr_frame_done = 1'b0;
        chk("restart_prime", valid, 0);
        tick;
        chk("restart_valid", valid, 1);
        chk("restart_data", data_out, 200);
        chk("restart_start", image_start, 1);
        repeat (40) tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
